// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between N_REQ byte streams.
// A grant is held until the owner ends its message, exhausts its burst budget or goes idle.
module uart_tx_arbiter #(
    parameter int N_REQ        = 2,
    parameter int MAX_BURST    = 64,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic               tx_valid_o,
    output logic [7:0]         tx_data_o,
    input  logic               tx_ready_i,
    output logic [N_REQ-1:0]   grant_o,
    output logic               busy_o,
    output logic               state_o
);

    localparam int            PW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);
    localparam logic [7:0]    MAX_B    = 8'(MAX_BURST);
    localparam logic [7:0]    IDLE_T   = 8'(IDLE_TIMEOUT);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d, cand;
    logic [N_REQ-1:0] grant_d;
    logic [7:0]       burst_q, burst_d, burst_inc;
    logic [7:0]       idle_q, idle_d, idle_inc;
    logic             own_valid, own_last;
    logic [7:0]       own_data;
    logic             out_free, accept, found, release_now;

    // Handshakes: a byte moves from requester k when req_valid_i[k] && req_ready_o[k],
    // and toward uart_tx when tx_valid_o && tx_ready_i; valid never depends on ready.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = 8'h00;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_o[k]) begin
                own_valid = req_valid_i[k];
                own_last  = req_last_i[k];
                own_data  = req_data_i[8*k +: 8];
            end
        end
    end

    assign out_free    = !tx_valid_o || tx_ready_i;
    assign accept      = own_valid && out_free;
    assign req_ready_o = out_free ? grant_o : '0;
    assign busy_o      = (state_q == GRANT) || tx_valid_o;
    assign state_o     = state_q;

    // Counters saturate so a stuck owner can never wrap back below a release threshold.
    assign burst_inc = (burst_q == 8'hFF) ? burst_q : burst_q + 8'd1;
    assign idle_inc  = (idle_q == 8'hFF) ? idle_q : idle_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_o;
        burst_d     = burst_q;
        idle_d      = idle_q;
        found       = 1'b0;
        cand        = ptr_q;
        release_now = 1'b0;
        case (state_q)
            IDLE: begin
                // Search starts just after the previous owner, wrapping modulo N_REQ.
                for (int i = 0; i < N_REQ; i++) begin
                    cand = (cand == LAST_IDX) ? '0 : cand + PW'(1);
                    if (!found && req_valid_i[cand]) begin
                        found = 1'b1;
                        ptr_d = cand;
                    end
                end
                if (found) begin
                    state_d = GRANT;
                    grant_d = N_REQ'(1) << ptr_d;
                    burst_d = 8'd0;
                    idle_d  = 8'd0;
                end
            end
            GRANT: begin
                if (accept) burst_d = burst_inc;
                idle_d = own_valid ? 8'd0 : idle_inc;
                release_now = (accept && (own_last || (burst_inc >= MAX_B))) ||
                              (!own_valid && (idle_inc >= IDLE_T));
                if (release_now) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            ptr_q      <= LAST_IDX;
            grant_o    <= '0;
            burst_q    <= 8'd0;
            idle_q     <= 8'd0;
            tx_valid_o <= 1'b0;
            tx_data_o  <= 8'h00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_o <= grant_d;
            burst_q <= burst_d;
            idle_q  <= idle_d;
            // Release does not flush the output register; a pending byte still completes.
            if (accept) begin
                tx_valid_o <= 1'b1;
                tx_data_o  <= own_data;
            end else if (tx_ready_i) begin
                tx_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a cycle-level behavioural model with a byte scoreboard.
module tb_uart_tx_arbiter;

    localparam int N    = 2;
    localparam int MAXB = 4;
    localparam int TO   = 16;
    localparam int NV   = 14;

    typedef struct packed {
        logic [N-1:0]   valid;
        logic [8*N-1:0] data;
        logic [N-1:0]   last;
        logic           txr;
        logic [N-1:0]   grant;
        logic [N-1:0]   rdy;
        logic           tv;
        logic [7:0]     td;
        logic           busy;
    } vec_t;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic           clk     = 1'b0;
    logic           rstn    = 1'b0;
    logic [N-1:0]   v_valid = '0;
    logic [8*N-1:0] v_data  = '0;
    logic [N-1:0]   v_last  = '0;
    logic           v_txr   = 1'b0;
    logic [N-1:0]   req_ready, grant;
    logic           tx_valid, busy, state;
    logic [7:0]     tx_data;

    int         checks = 0;
    int         errors = 0;
    vec_t       vecs[NV];
    beat_t      src_q[N][$];
    logic [7:0] exp_q[$];
    int         grant_log[$];
    int         start_cyc[N];
    int         gap[N];
    int         gap_pct;
    int         hs_cnt[256];
    int         total_hs;
    logic [N-1:0] prev_grant;

    // Behavioural model state: owner index (-1 when idle), rr pointer, output slot.
    int         m_owner, m_ptr, m_burst, m_idle;
    bit         m_full;
    logic [7:0] m_byte;

    uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MAXB), .IDLE_TIMEOUT(TO)) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .req_valid_i(v_valid),
        .req_data_i (v_data),
        .req_last_i (v_last),
        .req_ready_o(req_ready),
        .tx_valid_o (tx_valid),
        .tx_data_o  (tx_data),
        .tx_ready_i (v_txr),
        .grant_o    (grant),
        .busy_o     (busy),
        .state_o    (state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rstn && tx_valid && v_txr) begin
            hs_cnt[tx_data] = hs_cnt[tx_data] + 1;
            total_hs = total_hs + 1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/underflow expected completion", name);
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        v_valid = '0;
        v_data  = '0;
        v_last  = '0;
        v_txr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 32'(grant), 32'(0));
        check("rst_ready", 32'(req_ready), 32'(0));
        check("rst_tx_valid", 32'(tx_valid), 32'(0));
        check("rst_tx_data", 32'(tx_data), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        for (int k = 0; k < N; k++) begin
            src_q[k].delete();
            start_cyc[k] = 0;
            gap[k] = 0;
        end
        for (int b = 0; b < 256; b++) hs_cnt[b] = 0;
        exp_q.delete();
        grant_log.delete();
        total_hs   = 0;
        gap_pct    = 0;
        prev_grant = '0;
        m_owner = -1;
        m_ptr   = N - 1;
        m_burst = 0;
        m_idle  = 0;
        m_full  = 1'b0;
        m_byte  = 8'h00;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    function automatic bit pending();
        bit p;
        p = (m_owner >= 0) || m_full;
        for (int k = 0; k < N; k++) if (src_q[k].size() > 0) p = 1'b1;
        return p;
    endfunction

    // One model cycle: compare DUT against model, run scoreboard, then advance model state.
    task automatic model_cycle();
        logic [N-1:0] eg, er;
        bit           can_take, took, rel, found;
        int           o, c;
        can_take = !m_full || v_txr;
        eg = '0;
        er = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            if (can_take) er[m_owner] = 1'b1;
        end
        check("m_grant", 32'(grant), 32'(eg));
        check("m_ready", 32'(req_ready), 32'(er));
        check("m_tx_valid", 32'(tx_valid), 32'(m_full));
        check("m_tx_data", 32'(tx_data), 32'(m_byte));
        check("m_busy", 32'(busy), 32'((m_owner >= 0) || m_full));
        if (grant != '0 && prev_grant == '0) begin
            for (int k = 0; k < N; k++) if (grant[k]) grant_log.push_back(k);
        end
        prev_grant = grant;
        if (tx_valid && v_txr) begin
            if (exp_q.size() == 0) fail_now("sb_extra_byte");
            else check("sb_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
        o = m_owner;
        took = (o >= 0) && v_valid[o] && can_take;
        if (took) begin
            m_full = 1'b1;
            m_byte = v_data[8*o +: 8];
            exp_q.push_back(m_byte);
            void'(src_q[o].pop_front());
            if ($urandom_range(99) < 32'(gap_pct)) gap[o] = $urandom_range(25, 5);
        end else if (v_txr) begin
            m_full = 1'b0;
        end
        if (o < 0) begin
            found = 1'b0;
            for (int j = 1; j <= N; j++) begin
                c = (m_ptr + j) % N;
                if (!found && v_valid[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_ptr   = c;
                    m_burst = 0;
                    m_idle  = 0;
                end
            end
        end else begin
            rel = 1'b0;
            if (took) begin
                m_burst++;
                if (v_last[o] || m_burst >= MAXB) rel = 1'b1;
            end
            if (v_valid[o]) m_idle = 0;
            else begin
                m_idle++;
                if (m_idle >= TO) rel = 1'b1;
            end
            if (rel) m_owner = -1;
        end
    endtask

    // Driver: each requester presents the head of its queue, with random gaps and drops.
    task automatic run_engine(input int ready_pct, input int drop_pct, input int limit);
        int cyc;
        cyc = 0;
        while (pending() && cyc < limit) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                v_valid[k]       = 1'b0;
                v_data[8*k +: 8] = 8'($urandom);
                v_last[k]        = 1'($urandom);
                if (gap[k] > 0) gap[k]--;
                else if (cyc >= start_cyc[k] && src_q[k].size() > 0 &&
                         $urandom_range(99) >= 32'(drop_pct)) begin
                    v_valid[k]       = 1'b1;
                    v_data[8*k +: 8] = src_q[k][0].d;
                    v_last[k]        = src_q[k][0].l;
                end
            end
            v_txr = ($urandom_range(99) < 32'(ready_pct));
            @(negedge clk);
            model_cycle();
            cyc++;
        end
        if (pending()) fail_now("engine_timeout");
        @(posedge clk);
        #1;
        v_valid = '0;
        v_txr   = 1'b0;
        check("sb_drained", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int held, idx, loaded, n;
        bit done;
        int t3_exp[4];
        beat_t b;

        // Per cycle: valid, data, last, tx_ready | grant, ready, tx_valid, tx_data, busy
        vecs[0]  = '{2'b01, 16'h0041, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{2'b01, 16'h0041, 2'b00, 1'b1, 2'b01, 2'b01, 1'b0, 8'h00, 1'b1};
        vecs[2]  = '{2'b01, 16'h0042, 2'b00, 1'b1, 2'b01, 2'b01, 1'b1, 8'h41, 1'b1};
        vecs[3]  = '{2'b01, 16'h0043, 2'b01, 1'b1, 2'b01, 2'b01, 1'b1, 8'h42, 1'b1};
        vecs[4]  = '{2'b00, 16'h0000, 2'b00, 1'b1, 2'b00, 2'b00, 1'b1, 8'h43, 1'b1};
        vecs[5]  = '{2'b00, 16'h0000, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 8'h43, 1'b0};
        vecs[6]  = '{2'b10, 16'h5500, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 8'h43, 1'b0};
        vecs[7]  = '{2'b10, 16'h5500, 2'b10, 1'b0, 2'b10, 2'b10, 1'b0, 8'h43, 1'b1};
        vecs[8]  = '{2'b00, 16'h0000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 8'h55, 1'b1};
        vecs[9]  = '{2'b01, 16'h0066, 2'b01, 1'b0, 2'b00, 2'b00, 1'b1, 8'h55, 1'b1};
        vecs[10] = '{2'b01, 16'h0066, 2'b01, 1'b0, 2'b01, 2'b00, 1'b1, 8'h55, 1'b1};
        vecs[11] = '{2'b01, 16'h0066, 2'b01, 1'b1, 2'b01, 2'b01, 1'b1, 8'h55, 1'b1};
        vecs[12] = '{2'b00, 16'h0000, 2'b00, 1'b1, 2'b00, 2'b00, 1'b1, 8'h66, 1'b1};
        vecs[13] = '{2'b00, 16'h0000, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 8'h66, 1'b0};

        // Vector table: single message, rr handover, new grant while output register full
        do_reset();
        for (int i = 0; i < NV; i++) begin
            v_valid = vecs[i].valid;
            v_data  = vecs[i].data;
            v_last  = vecs[i].last;
            v_txr   = vecs[i].txr;
            @(negedge clk);
            check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].grant));
            check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].rdy));
            check($sformatf("vec%0d_tx_valid", i), 32'(tx_valid), 32'(vecs[i].tv));
            check($sformatf("vec%0d_tx_data", i), 32'(tx_data), 32'(vecs[i].td));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            step();
        end
        check("t1_handshakes", 32'(total_hs), 32'(5));

        // Two requesters, four 2-byte messages each: grants alternate starting with 0
        do_reset();
        for (int m = 0; m < 4; m++) begin
            b.d = 8'(8'h10 + 2*m); b.l = 1'b0; src_q[0].push_back(b);
            b.d = 8'(8'h11 + 2*m); b.l = 1'b1; src_q[0].push_back(b);
            b.d = 8'(8'h20 + 2*m); b.l = 1'b0; src_q[1].push_back(b);
            b.d = 8'(8'h21 + 2*m); b.l = 1'b1; src_q[1].push_back(b);
        end
        run_engine(100, 0, 500);
        check("t2_grant_count", 32'(grant_log.size()), 32'(8));
        for (int i = 0; i < grant_log.size(); i++)
            check($sformatf("t2_grant%0d", i), 32'(grant_log[i]), 32'(i % 2));

        // Burst budget: req1 streams 10 bytes, req0 joins one cycle later
        do_reset();
        for (int i = 0; i < 10; i++) begin
            b.d = 8'(8'h30 + i); b.l = 1'b0; src_q[1].push_back(b);
        end
        b.d = 8'h40; b.l = 1'b0; src_q[0].push_back(b);
        b.d = 8'h41; b.l = 1'b1; src_q[0].push_back(b);
        start_cyc[0] = 1;
        run_engine(100, 0, 500);
        t3_exp = '{1, 0, 1, 1};
        check("t3_grant_count", 32'(grant_log.size()), 32'(4));
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check($sformatf("t3_grant%0d", i), 32'(grant_log[i]), 32'(t3_exp[i]));

        // Idle timeout: owner drops valid, waiting req1 gets the next grant
        do_reset();
        v_valid = 2'b01; v_data = 16'h0070; v_last = 2'b00; v_txr = 1'b1;
        @(negedge clk);
        check("t4_c0_grant", 32'(grant), 32'(0));
        step();
        @(negedge clk);
        check("t4_c1_grant", 32'(grant), 32'(2'b01));
        check("t4_c1_ready", 32'(req_ready), 32'(2'b01));
        step();
        v_valid = 2'b10; v_data = 16'h7100; v_last = 2'b10;
        held = 0; done = 1'b0; idx = 0;
        while (!done && idx < 40) begin
            @(negedge clk);
            if (grant == 2'b01) begin
                held++;
                check("t4_wait_ready1", 32'(req_ready[1]), 32'(0));
                step();
            end else begin
                done = 1'b1;
            end
            idx++;
        end
        if (!done) fail_now("t4_timeout");
        check("t4_hold_cycles", 32'(held), 32'(TO));
        check("t4_release", 32'(grant), 32'(0));
        step();
        @(negedge clk);
        check("t4_next_grant", 32'(grant), 32'(2'b10));
        step();
        v_valid = '0;
        repeat (3) step();

        // Backpressure: 0x55 held for 20 cycles, then exactly one handshake
        do_reset();
        v_valid = 2'b01; v_data = 16'h0055; v_last = 2'b00; v_txr = 1'b0;
        step();
        @(negedge clk);
        check("t5_accept_ready", 32'(req_ready), 32'(2'b01));
        step();
        v_data = 16'h0056; v_last = 2'b01;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t5_hold_valid", 32'(tx_valid), 32'(1));
            check("t5_hold_data", 32'(tx_data), 32'(8'h55));
            check("t5_hold_ready", 32'(req_ready), 32'(0));
            step();
        end
        v_txr = 1'b1;
        @(negedge clk);
        check("t5_release_ready", 32'(req_ready), 32'(2'b01));
        step();
        v_valid = '0;
        @(negedge clk);
        check("t5_next_data", 32'(tx_data), 32'(8'h56));
        step();
        @(negedge clk);
        check("t5_drained", 32'(tx_valid), 32'(0));
        check("t5_hs_55", 32'(hs_cnt[8'h55]), 32'(1));
        check("t5_hs_56", 32'(hs_cnt[8'h56]), 32'(1));
        step();

        // Reset mid-transfer with a byte pending
        do_reset();
        v_valid = 2'b01; v_data = 16'h0099; v_last = 2'b00; v_txr = 1'b0;
        step();
        step();
        @(negedge clk);
        check("t6_pending", 32'(tx_valid), 32'(1));
        #2;
        rstn = 1'b0;
        #1;
        check("t6_async_tx_valid", 32'(tx_valid), 32'(0));
        check("t6_async_tx_data", 32'(tx_data), 32'(0));
        check("t6_async_grant", 32'(grant), 32'(0));
        check("t6_async_ready", 32'(req_ready), 32'(0));
        check("t6_async_busy", 32'(busy), 32'(0));
        v_valid = 2'b10; v_data = 16'h3300; v_last = 2'b10; v_txr = 1'b1;
        step();
        step();
        rstn = 1'b1;
        @(negedge clk);
        check("t6_c0_grant", 32'(grant), 32'(0));
        step();
        @(negedge clk);
        check("t6_c1_grant", 32'(grant), 32'(2'b10));
        check("t6_c1_ready", 32'(req_ready), 32'(2'b10));
        step();
        v_valid = '0;
        @(negedge clk);
        check("t6_tx_data", 32'(tx_data), 32'(8'h33));
        step();
        @(negedge clk);
        check("t6_no_stale", 32'(hs_cnt[8'h99]), 32'(0));
        check("t6_hs_33", 32'(hs_cnt[8'h33]), 32'(1));
        step();

        // Randomized traffic against the model
        for (int r = 0; r < 3; r++) begin
            do_reset();
            gap_pct = r * 10;
            loaded = 0;
            for (int k = 0; k < N; k++) begin
                n = $urandom_range(30, 10);
                for (int i = 0; i < n; i++) begin
                    b.d = 8'($urandom);
                    b.l = ($urandom_range(3) == 0) || (i == n - 1);
                    src_q[k].push_back(b);
                end
                loaded += n;
                start_cyc[k] = $urandom_range(5);
            end
            run_engine(40 + 25 * r, 10 * r, 8000);
            check($sformatf("rand%0d_total", r), 32'(total_hs), 32'(loaded));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
